// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_pkg
//  Description : Shared constants and width helper for the debouncer bank.
//  Revision    : 1.0 - initial release
// ============================================================================
package debounce_pkg;

    // Reference system clock and the prescaler divide that gives a 1 ms tick.
    localparam int DB_CLK_HZ         = 50_000_000;
    localparam int DB_DIV_1MS        = 50000;
    localparam int DB_STABLE_DEFAULT = 4;

    // Counter width helper built on $clog2. The prescaler uses
    // db_cnt_width(DIV) to count 0..DIV-1; the stability counter uses
    // db_cnt_width(STABLE+1). The result is clamped to at least one bit so
    // that degenerate sizes never produce a zero-width vector.
    function automatic int db_cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_channel
//  Description : One debounced bit: two-flop synchroniser, consecutive-tick
//                stability counter, registered level and rise/fall strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int STABLE = DB_STABLE_DEFAULT
) (
    input  logic clk,
    input  logic rst_a_n,
    input  logic en,
    input  logic tick,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    localparam int              CW   = db_cnt_width(STABLE + 1);
    localparam logic [CW-1:0]   LAST = CW'(STABLE - 1);

    logic          sync_q1;
    logic          sync_q2;
    logic [CW-1:0] cnt;

    // Bring the raw asynchronous input into the clock domain; runs even when disabled.
    always_ff @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= din;
            sync_q2 <= sync_q1;
        end
    end

    // Count consecutive ticks that disagree with dout; accept the new level on the last one.
    always_ff @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) begin
            cnt  <= '0;
            dout <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (!en) begin
                cnt <= '0;
            end else if (tick) begin
                if (sync_q2 == dout) begin
                    cnt <= '0;
                end else if (cnt == LAST) begin
                    cnt  <= '0;
                    dout <= sync_q2;
                    rise <= sync_q2;
                    fall <= ~sync_q2;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/debouncer_bank.sv
`default_nettype none
// ============================================================================
//  Module      : debouncer_bank
//  Description : Multi-channel debouncer sharing one sample-tick prescaler.
//  Revision    : 1.0 - initial release
// ============================================================================
module debouncer_bank
    import debounce_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int DIV      = DB_DIV_1MS,
    parameter int STABLE   = DB_STABLE_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_a_n,
    input  logic                en,
    input  logic [CHANNELS-1:0] din,
    output logic [CHANNELS-1:0] dout,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic                tick
);

    localparam int            PW       = db_cnt_width(DIV);
    localparam logic [PW-1:0] DIV_LAST = PW'(DIV - 1);

    logic [PW-1:0] presc;

    // The tick is decoded from the prescaler and gated by en so a disabled bank never samples.
    always_comb begin
        tick = en && (presc == DIV_LAST);
    end

    // Free-running 0..DIV-1 prescaler, parked at zero while disabled.
    always_ff @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) begin
            presc <= '0;
        end else if (!en) begin
            presc <= '0;
        end else if (presc == DIV_LAST) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        debounce_channel #(
            .STABLE (STABLE)
        ) u_chan (
            .clk     (clk),
            .rst_a_n (rst_a_n),
            .en      (en),
            .tick    (tick),
            .din     (din[g]),
            .dout    (dout[g]),
            .rise    (rise[g]),
            .fall    (fall[g])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_debouncer_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_debouncer_bank
//  Description : Self-checking bench for debouncer_bank (CHANNELS=2, DIV=4,
//                STABLE=3, plus a STABLE=1 instance).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_debouncer_bank;

    logic       clk = 1'b0;
    logic       rst_a_n;
    logic       en;
    logic [1:0] din;
    logic [1:0] dout0, rise0, fall0;
    logic       tick0;

    logic       rst1_n;
    logic       en1;
    logic [1:0] din1;
    logic [1:0] dout1, rise1, fall1;
    logic       tick1;

    logic       sel;
    logic [1:0] obs_dout, obs_rise, obs_fall;
    logic       obs_tick;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic       tick_x;
        logic [1:0] dout_x;
        logic [1:0] rise_x;
        logic [1:0] fall_x;
    } row_t;

    row_t tbl [16];

    always #5 clk = ~clk;

    debouncer_bank #(.CHANNELS(2), .DIV(4), .STABLE(3)) u_dut0 (
        .clk     (clk),
        .rst_a_n (rst_a_n),
        .en      (en),
        .din     (din),
        .dout    (dout0),
        .rise    (rise0),
        .fall    (fall0),
        .tick    (tick0)
    );

    debouncer_bank #(.CHANNELS(2), .DIV(4), .STABLE(1)) u_dut1 (
        .clk     (clk),
        .rst_a_n (rst1_n),
        .en      (en1),
        .din     (din1),
        .dout    (dout1),
        .rise    (rise1),
        .fall    (fall1),
        .tick    (tick1)
    );

    // Route the instance under test to a common set of observation signals.
    always_comb begin
        obs_dout = sel ? dout1 : dout0;
        obs_rise = sel ? rise1 : rise0;
        obs_fall = sel ? fall1 : fall0;
        obs_tick = sel ? tick1 : tick0;
    end

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%b want=%b", name, cyc, act, exp);
        end
    endtask

    task automatic chk_quiet(input string name);
        chk({name, ":dout"}, obs_dout, 2'b00);
        chk({name, ":rise"}, obs_rise, 2'b00);
        chk({name, ":fall"}, obs_fall, 2'b00);
        chk({name, ":tick"}, {1'b0, obs_tick}, 2'b00);
    endtask

    // Run n cycles; strobe er/ef expected only at index at, dout switches d0->d1 there.
    // tph: first tick index (period 4), -1 = tick must stay low, -2 = tick not checked.
    task automatic watch(input string name, input int n, input int at,
                         input logic [1:0] er, input logic [1:0] ef,
                         input logic [1:0] d0, input logic [1:0] d1, input int tph);
        logic [1:0] xr, xf, xd;
        logic       xt;
        for (int k = 0; k < n; k++) begin
            step();
            xr = (k == at) ? er : 2'b00;
            xf = (k == at) ? ef : 2'b00;
            xd = (at >= 0 && k >= at) ? d1 : d0;
            chk({name, ":dout"}, obs_dout, xd);
            chk({name, ":rise"}, obs_rise, xr);
            chk({name, ":fall"}, obs_fall, xf);
            if (tph != -2) begin
                xt = (tph >= 0) && (k >= tph) && (((k - tph) % 4) == 0);
                chk({name, ":tick"}, {1'b0, obs_tick}, {1'b0, xt});
            end
        end
    endtask

    initial begin
        // Expected outputs for cycles 1..16 after reset release with din=11 held.
        tbl[0]  = '{1'b0, 2'b00, 2'b00, 2'b00};
        tbl[1]  = '{1'b0, 2'b00, 2'b00, 2'b00};
        tbl[2]  = '{1'b1, 2'b00, 2'b00, 2'b00};
        tbl[3]  = '{1'b0, 2'b00, 2'b00, 2'b00};
        tbl[4]  = '{1'b0, 2'b00, 2'b00, 2'b00};
        tbl[5]  = '{1'b0, 2'b00, 2'b00, 2'b00};
        tbl[6]  = '{1'b1, 2'b00, 2'b00, 2'b00};
        tbl[7]  = '{1'b0, 2'b00, 2'b00, 2'b00};
        tbl[8]  = '{1'b0, 2'b00, 2'b00, 2'b00};
        tbl[9]  = '{1'b0, 2'b00, 2'b00, 2'b00};
        tbl[10] = '{1'b1, 2'b00, 2'b00, 2'b00};
        tbl[11] = '{1'b0, 2'b11, 2'b11, 2'b00};
        tbl[12] = '{1'b0, 2'b11, 2'b00, 2'b00};
        tbl[13] = '{1'b0, 2'b11, 2'b00, 2'b00};
        tbl[14] = '{1'b1, 2'b11, 2'b00, 2'b00};
        tbl[15] = '{1'b0, 2'b11, 2'b00, 2'b00};

        sel     = 1'b0;
        rst_a_n = 1'b0;
        en      = 1'b1;
        din     = 2'b11;
        rst1_n  = 1'b0;
        en1     = 1'b1;
        din1    = 2'b00;

        // Reset held with din=11: everything quiet.
        for (int i = 0; i < 4; i++) begin
            step();
            chk_quiet("in_reset");
        end
        rst_a_n = 1'b1;

        // Table: first tick in cycle 3, both channels rise together.
        for (int i = 0; i < 16; i++) begin
            step();
            chk("tbl:tick", {1'b0, obs_tick}, {1'b0, tbl[i].tick_x});
            chk("tbl:dout", obs_dout, tbl[i].dout_x);
            chk("tbl:rise", obs_rise, tbl[i].rise_x);
            chk("tbl:fall", obs_fall, tbl[i].fall_x);
        end

        // Simultaneous fall after 3 ticks.
        din = 2'b00;
        watch("fall_both", 16, 11, 2'b00, 2'b11, 2'b11, 2'b00, 2);

        // Clean step on channel 0 only.
        din = 2'b01;
        watch("rise0", 16, 11, 2'b01, 2'b00, 2'b00, 2'b01, 2);
        din = 2'b00;
        watch("fall0", 16, 11, 2'b00, 2'b01, 2'b01, 2'b00, 2);

        // Bounce rejection: 6 clk high / 6 clk low, repeated.
        for (int r = 0; r < 10; r++) begin
            din = 2'b01;
            watch("bounce_hi", 6, -1, 2'b00, 2'b00, 2'b00, 2'b00, -2);
            din = 2'b00;
            watch("bounce_lo", 6, -1, 2'b00, 2'b00, 2'b00, 2'b00, -2);
        end
        watch("bounce_tail", 8, -1, 2'b00, 2'b00, 2'b00, 2'b00, -2);

        // Enable gating: align to a tick, step din[1], drop en after 2 ticks.
        begin
            int  w;
            w = 0;
            while (!obs_tick && w < 8) begin
                step();
                w++;
            end
            checks++;
            if (!obs_tick) begin
                errors++;
                $display("FAIL tick_align cycle=%0d got=%b want=1", cyc, obs_tick);
            end
        end
        din = 2'b10;
        watch("en_pre", 9, -1, 2'b00, 2'b00, 2'b00, 2'b00, 3);
        en = 1'b0;
        watch("en_off", 12, -1, 2'b00, 2'b00, 2'b00, 2'b00, -1);
        en = 1'b1;
        watch("en_on", 16, 11, 2'b10, 2'b00, 2'b00, 2'b10, 2);

        // Reset mid-operation: dout[0]=1, din[0] falls, reset after 2 differing ticks.
        din = 2'b11;
        watch("mid_up", 14, 11, 2'b01, 2'b00, 2'b10, 2'b11, 2);
        din = 2'b10;
        watch("mid_pend", 10, -1, 2'b00, 2'b00, 2'b11, 2'b11, 0);
        rst_a_n = 1'b0;
        #1;
        chk_quiet("mid_async");
        step();
        chk_quiet("mid_hold");
        rst_a_n = 1'b1;
        watch("mid_rel", 16, 11, 2'b10, 2'b00, 2'b00, 2'b10, 2);

        // STABLE=1 instance: first differing tick updates dout.
        sel    = 1'b1;
        din1   = 2'b01;
        rst1_n = 1'b1;
        watch("s1_rise", 8, 3, 2'b01, 2'b00, 2'b00, 2'b01, 2);
        din1 = 2'b00;
        watch("s1_fall", 8, 3, 2'b00, 2'b01, 2'b01, 2'b00, 2);
        din1 = 2'b01;
        watch("s1_rise2", 8, 3, 2'b01, 2'b00, 2'b00, 2'b01, 2);
        din1 = 2'b00;
        watch("s1_pend", 2, -1, 2'b00, 2'b00, 2'b01, 2'b01, 2);
        rst1_n = 1'b0;
        #1;
        chk_quiet("s1_async");
        step();
        chk_quiet("s1_hold");
        rst1_n = 1'b1;
        watch("s1_post", 8, -1, 2'b00, 2'b00, 2'b00, 2'b00, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
